// File: rtl/secded_pkg.sv
// Shared types and Hamming(16,11) SECDED helpers for the memory-to-memory engine.
// Bit k of a codeword sits at Hamming position k; position 0 holds overall parity.
package secded_pkg;

  typedef logic [11:1] data_t;
  typedef logic [15:0] cw_t;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_SGL = 2'b01,
    ST_DBL = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  function automatic cw_t encode(data_t d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // Each syndrome bit is the parity of the positions whose index has that bit set.
  function automatic logic [3:0] syndrome(cw_t cw);
    logic [3:0] s;
    s[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7] ^ cw[9] ^ cw[11] ^ cw[13] ^ cw[15];
    s[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11] ^ cw[14] ^ cw[15];
    s[2] = (^cw[7:4]) ^ (^cw[15:12]);
    s[3] = ^cw[15:8];
    return s;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED codec: encode mode takes data in cw[10:0], decode mode corrects/classifies cw.
// Zero latency; no flow control, the engine samples the result in its CAP state.
module secded_codec
  import secded_pkg::*;
(
  input  logic    mode,
  input  cw_t     cw,
  output cw_t     result,
  output status_e status
);

  logic [3:0] s;
  logic       q;
  cw_t        fixed;
  data_t      d;

  always_comb begin
    s      = syndrome(cw);
    q      = ^cw;
    fixed  = cw;
    status = ST_OK;
    d      = '0;
    result = '0;
    if (!mode) begin
      result = encode(cw[10:0]);
    end else begin
      // Odd overall parity means one flipped bit, located by the syndrome (0 = p0 itself).
      if (q) begin
        fixed  = cw ^ (16'd1 << s);
        status = ST_SGL;
      end else if (s != 4'd0) begin
        status = ST_DBL;
      end
      d      = {fixed[15:9], fixed[7:5], fixed[3]};
      result = {status, 3'b000, d[11:9], d[8:1]};
    end
  end

endmodule

// File: rtl/secded_engine.sv
// Walks N_MSG 16-bit messages through the codec, reading src and writing dst byte memory.
// Five cycles per message; start is only accepted in IDLE/DONE, done holds until the next run.
module secded_engine
  import secded_pkg::*;
#(
  parameter int N_MSG    = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        cnt_single,
  output logic [7:0]        cnt_double
);

  if (N_MSG < 1) begin : g_chk_n
    $error("secded_engine: N_MSG must be at least 1");
  end
  if (SRC_BASE + 2 * N_MSG > 2 ** ADDR_W) begin : g_chk_src
    $error("secded_engine: source region exceeds address space");
  end
  if (DST_BASE + 2 * N_MSG > 2 ** ADDR_W) begin : g_chk_dst
    $error("secded_engine: destination region exceeds address space");
  end

  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_MSG - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_e            state, state_nxt;
  logic              mode_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] off;
  logic [7:0]        lo_q;
  cw_t               res_q;
  cw_t               codec_res;
  status_e           codec_st;

  assign off = {idx[ADDR_W-2:0], 1'b0};

  secded_codec u_codec (
    .mode   (mode_q),
    .cw     ({mem_rdata, lo_q}),
    .result (codec_res),
    .status (codec_st)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_RD_LO;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = S_RD_LO;
      end
      S_RD_LO: begin
        mem_addr  = SRC_A + off;
        state_nxt = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr  = SRC_A + off + ONE;
        state_nxt = S_CAP;
      end
      S_CAP: state_nxt = S_WR_LO;
      S_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = DST_A + off;
        mem_wdata = res_q[7:0];
        state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = DST_A + off + ONE;
        mem_wdata = res_q[15:8];
        state_nxt = (idx == LAST) ? S_DONE : S_RD_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      mode_q     <= 1'b0;
      lo_q       <= '0;
      res_q      <= '0;
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx        <= '0;
            mode_q     <= mode;
            cnt_single <= '0;
            cnt_double <= '0;
          end
        end
        S_RD_HI: lo_q <= mem_rdata;
        S_CAP: begin
          res_q <= codec_res;
          if (codec_st == ST_SGL && cnt_single != 8'hFF) cnt_single <= cnt_single + 8'd1;
          if (codec_st == ST_DBL && cnt_double != 8'hFF) cnt_double <= cnt_double + 8'd1;
        end
        S_WR_HI: if (idx != LAST) idx <= idx + ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_engine.sv
// Bench: three engine instances share one byte memory; results are checked against a positional Hamming model.
module tb_secded_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       md = 1'b0;
  logic [2:0] go = 3'b000;
  logic [2:0] busy_w, done_w, we_w;
  logic [7:0] addr_w [3];
  logic [7:0] wd_w [3];
  logic [7:0] cs_w [3];
  logic [7:0] cd_w [3];
  logic [7:0] rdata;
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  logic [7:0] tb_wd = 8'd0;
  logic       m_we;
  logic [7:0] m_addr, m_wd;
  int         we_cnt [3];
  int         checks = 0;
  int         errors = 0;
  logic [10:0] rnd [15];

  secded_engine #(.N_MSG(3), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) u_a (
    .clk(clk), .reset(reset), .start(go[0]), .mode(md), .busy(busy_w[0]), .done(done_w[0]),
    .mem_addr(addr_w[0]), .mem_we(we_w[0]), .mem_wdata(wd_w[0]), .mem_rdata(rdata),
    .cnt_single(cs_w[0]), .cnt_double(cd_w[0]));

  secded_engine #(.N_MSG(15), .SRC_BASE(0), .DST_BASE(30), .ADDR_W(8)) u_b (
    .clk(clk), .reset(reset), .start(go[1]), .mode(md), .busy(busy_w[1]), .done(done_w[1]),
    .mem_addr(addr_w[1]), .mem_we(we_w[1]), .mem_wdata(wd_w[1]), .mem_rdata(rdata),
    .cnt_single(cs_w[1]), .cnt_double(cd_w[1]));

  secded_engine #(.N_MSG(15), .SRC_BASE(30), .DST_BASE(30), .ADDR_W(8)) u_c (
    .clk(clk), .reset(reset), .start(go[2]), .mode(md), .busy(busy_w[2]), .done(done_w[2]),
    .mem_addr(addr_w[2]), .mem_we(we_w[2]), .mem_wdata(wd_w[2]), .mem_rdata(rdata),
    .cnt_single(cs_w[2]), .cnt_double(cd_w[2]));

  always_comb begin
    m_we   = tb_we;
    m_addr = tb_addr;
    m_wd   = tb_wd;
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k]) begin
        m_we   = we_w[k];
        m_addr = addr_w[k];
        m_wd   = wd_w[k];
      end
    end
  end

  always @(posedge clk) begin
    rdata <= mem[m_addr];
    if (m_we) mem[m_addr] <= m_wd;
    for (int k = 0; k < 3; k++) if (we_w[k]) we_cnt[k] <= we_cnt[k] + 1;
  end

  // Reference: data bits fill non-power-of-two positions in order, parity p(2^b) covers positions with bit b set.
  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        p;
    int          j;
    cw = '0;
    j  = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        cw[k] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if (((k >> b) & 1) != 0) p = p ^ cw[k];
      cw[1 << b] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] m_decode(input logic [15:0] cw);
    int          s;
    int          j;
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  st;
    s = 0;
    for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ k;
    c  = cw;
    st = 2'b00;
    if (^cw) begin
      c[s] = ~c[s];
      st   = 2'b01;
    end else if (s != 0) begin
      st = 2'b10;
    end
    d = '0;
    j = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = c[k];
        j++;
      end
    end
    return {st, 3'b000, d};
  endfunction

  function automatic logic [15:0] get_word(input int base, input int i);
    return {mem[base + 2 * i + 1], mem[base + 2 * i]};
  endfunction

  task automatic mem_write(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = 8'(a);
    tb_wd   = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic put_word(input int base, input int i, input logic [15:0] w);
    mem_write(base + 2 * i, w[7:0]);
    mem_write(base + 2 * i + 1, w[15:8]);
  endtask

  task automatic start_run(input int sel, input logic m);
    @(negedge clk);
    md      = m;
    go[sel] = 1'b1;
    @(negedge clk);
    go = 3'b000;
  endtask

  task automatic wait_done(input int sel, input int maxc, output int cyc);
    cyc = 0;
    while (done_w[sel] !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    if (done_w[sel] !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_w[k], done_w[k], we_w[k]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ctrl inst %0d got busy/done/we %b want 000", k, {busy_w[k], done_w[k], we_w[k]});
      end
      checks++;
      if ({addr_w[k], wd_w[k], cs_w[k], cd_w[k]} !== 32'h0) begin
        errors++;
        $display("FAIL reset_data inst %0d got addr/wd/cs/cd %h want 0", k, {addr_w[k], wd_w[k], cs_w[k], cd_w[k]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_encode_patterns;
    logic [15:0] exp [3];
    int cyc, we0;
    exp[0] = 16'h0000; exp[1] = 16'hFFFF; exp[2] = 16'h000F;
    put_word(0, 0, 16'hF800);
    put_word(0, 1, 16'h07FF);
    put_word(0, 2, 16'h0001);
    we0 = we_cnt[0];
    start_run(0, 1'b0);
    wait_done(0, 40, cyc);
    checks++;
    if (cyc !== 15) begin errors++; $display("FAIL enc_latency got %0d want 15", cyc); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_word(30, i) !== exp[i]) begin
        errors++;
        $display("FAIL enc_pattern %0d got %h want %h", i, get_word(30, i), exp[i]);
      end
    end
    checks++;
    if (we_cnt[0] - we0 !== 6) begin errors++; $display("FAIL enc_we_cycles got %0d want 6", we_cnt[0] - we0); end
  endtask

  task automatic test_decode_directed;
    int cyc;
    put_word(0, 0, 16'h000F);
    put_word(0, 1, 16'h002F);
    put_word(0, 2, 16'hFFFE);
    start_run(0, 1'b1);
    wait_done(0, 40, cyc);
    checks++;
    if (cyc !== 15) begin errors++; $display("FAIL dec_latency got %0d want 15", cyc); end
    checks++;
    if (get_word(30, 0) !== 16'h0001) begin errors++; $display("FAIL dec_clean got %h want 0001", get_word(30, 0)); end
    checks++;
    if (get_word(30, 1) !== 16'h4001) begin errors++; $display("FAIL dec_bit5 got %h want 4001", get_word(30, 1)); end
    checks++;
    if (get_word(30, 2) !== 16'h47FF) begin errors++; $display("FAIL dec_p0 got %h want 47ff", get_word(30, 2)); end
    checks++;
    if ({cs_w[0], cd_w[0]} !== {8'd2, 8'd0}) begin
      errors++;
      $display("FAIL dec_counts1 got %0d/%0d want 2/0", cs_w[0], cd_w[0]);
    end
    put_word(0, 0, 16'hFFF9);
    put_word(0, 1, 16'h000F);
    put_word(0, 2, 16'h0000);
    start_run(0, 1'b1);
    checks++;
    if ({done_w[0], cs_w[0], cd_w[0]} !== 17'h0) begin
      errors++;
      $display("FAIL restart_clear got done %b cs %0d cd %0d want 0", done_w[0], cs_w[0], cd_w[0]);
    end
    wait_done(0, 40, cyc);
    checks++;
    if (get_word(30, 0) !== 16'h87FF) begin errors++; $display("FAIL dec_double got %h want 87ff", get_word(30, 0)); end
    checks++;
    if ({get_word(30, 1), get_word(30, 2)} !== 32'h0001_0000) begin
      errors++;
      $display("FAIL dec_clean2 got %h %h want 0001 0000", get_word(30, 1), get_word(30, 2));
    end
    checks++;
    if ({cs_w[0], cd_w[0]} !== {8'd0, 8'd1}) begin
      errors++;
      $display("FAIL dec_counts2 got %0d/%0d want 0/1", cs_w[0], cd_w[0]);
    end
  endtask

  task automatic test_start_ignored;
    logic [10:0] d [3];
    int cyc;
    for (int i = 0; i < 3; i++) begin
      d[i] = 11'($urandom_range(0, 2047));
      put_word(0, i, {5'($urandom_range(0, 31)), d[i]});
    end
    start_run(0, 1'b0);
    repeat (3) @(negedge clk);
    go[0] = 1'b1;
    md    = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    wait_done(0, 40, cyc);
    checks++;
    if (cyc + 4 !== 15) begin errors++; $display("FAIL busy_start_latency got %0d want 15", cyc + 4); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_word(30, i) !== m_encode(d[i])) begin
        errors++;
        $display("FAIL busy_start_data %0d got %h want %h", i, get_word(30, i), m_encode(d[i]));
      end
    end
  endtask

  task automatic test_encode_regression;
    int cyc;
    for (int i = 0; i < 15; i++) begin
      rnd[i] = 11'($urandom_range(0, 2047));
      put_word(0, i, {5'($urandom_range(0, 31)), rnd[i]});
    end
    start_run(1, 1'b0);
    wait_done(1, 200, cyc);
    checks++;
    if (cyc !== 75) begin errors++; $display("FAIL reg_latency got %0d want 75", cyc); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (get_word(30, i) !== m_encode(rnd[i])) begin
        errors++;
        $display("FAIL reg_encode %0d data %h got %h want %h", i, rnd[i], get_word(30, i), m_encode(rnd[i]));
      end
    end
  endtask

  task automatic test_roundtrip_inplace;
    int cyc;
    logic [15:0] w;
    for (int i = 0; i < 15; i++) begin
      w = get_word(30, i);
      w = w ^ (16'd1 << $urandom_range(0, 15));
      put_word(30, i, w);
    end
    start_run(2, 1'b1);
    wait_done(2, 200, cyc);
    checks++;
    if (cyc !== 75) begin errors++; $display("FAIL rt_latency got %0d want 75", cyc); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (get_word(30, i) !== {2'b01, 3'b000, rnd[i]}) begin
        errors++;
        $display("FAIL rt_restore %0d got %h want %h", i, get_word(30, i), {2'b01, 3'b000, rnd[i]});
      end
    end
    checks++;
    if ({cs_w[2], cd_w[2]} !== {8'd15, 8'd0}) begin
      errors++;
      $display("FAIL rt_counts got %0d/%0d want 15/0", cs_w[2], cd_w[2]);
    end
  endtask

  task automatic test_decode_random;
    logic [15:0] cw [15];
    int nflip, b1, b2, cyc, es, ed;
    es = 0;
    ed = 0;
    for (int i = 0; i < 15; i++) begin
      cw[i] = m_encode(11'($urandom_range(0, 2047)));
      nflip = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (nflip >= 1) cw[i][b1] = ~cw[i][b1];
      if (nflip == 2) cw[i][b2] = ~cw[i][b2];
      if (nflip == 1) es++;
      if (nflip == 2) ed++;
      put_word(0, i, cw[i]);
    end
    start_run(1, 1'b1);
    wait_done(1, 200, cyc);
    checks++;
    if (cyc !== 75) begin errors++; $display("FAIL rdec_latency got %0d want 75", cyc); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (get_word(30, i) !== m_decode(cw[i])) begin
        errors++;
        $display("FAIL rdec_word %0d cw %h got %h want %h", i, cw[i], get_word(30, i), m_decode(cw[i]));
      end
    end
    checks++;
    if ({cs_w[1], cd_w[1]} !== {8'(es), 8'(ed)}) begin
      errors++;
      $display("FAIL rdec_counts got %0d/%0d want %0d/%0d", cs_w[1], cd_w[1], es, ed);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    start_run(1, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy_w[1], done_w[1], we_w[1]} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset got busy/done/we %b want 000", {busy_w[1], done_w[1], we_w[1]});
    end
    wait_done(1, 90, cyc);
    checks++;
    if (cyc !== -1) begin errors++; $display("FAIL midrun_no_done got done after %0d cycles want none", cyc); end
    @(negedge clk);
    go[1] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    go    = 3'b000;
    reset = 1'b0;
    checks++;
    if ({busy_w[1], done_w[1]} !== 2'b00) begin
      errors++;
      $display("FAIL start_vs_reset got busy/done %b want 00", {busy_w[1], done_w[1]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encode_patterns();
    test_decode_directed();
    test_start_ignored();
    test_encode_regression();
    test_roundtrip_inplace();
    test_decode_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secded_engine.md
# secded_engine

Memory-to-memory Hamming SECDED engine, the parametrised successor to the program-1 encoder flow. On a `start` pulse it walks `N_MSG` messages in byte-wide data memory. In encode mode it inserts parity into 11-bit messages to form 16-bit codewords. In decode mode it checks and corrects codewords and reports error status. It sits beside the core on the data-memory port and is driven by the same `start`/`done` handshake as the core top level.

## Interface
- `N_MSG`, 15: messages per run; at least 1.
- `SRC_BASE`, 0: byte address of the first source message.
- `DST_BASE`, 30: byte address of the first result.
- `ADDR_W`, 8: memory address width. Elaboration assertion: `SRC_BASE+2*N_MSG` ≤ 2^`ADDR_W` and `DST_BASE+2*N_MSG` ≤ 2^`ADDR_W`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request, sampled only in IDLE/DONE.
- `mode` in 1: 0 = encode, 1 = decode; sampled with `start`.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held high until the next accepted `start` or `reset`.
- `mem_addr` out `ADDR_W`: byte address.
- `mem_we` out 1: write enable.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: read byte, valid the cycle after `mem_addr` is presented (synchronous read).
- `cnt_single` out 8: count of corrected single errors this run; saturates at 255.
- `cnt_double` out 8: count of detected double errors this run; saturates at 255.

## Operation
- **Message i layout.** Low byte is at base+2i, high byte at base+2i+1.
- **Encode source.** Data d[11:1] is {src hi[2:0], src lo[7:0]}; src hi[7:3] is ignored.
- **Codeword.** cw[15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}, where:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8^p4^p2^p1
- **Encode output.** dst lo = cw[7:0], dst hi = cw[15:8].
- **Decode input.** cw = {src hi, src lo}.
  - Syndrome s[3:0] = XOR of the indices k (1..15) for which cw[k] = 1.
  - Overall parity q = ^cw.
- **Decode classification.**
  - q=0, s=0: status 00, data unchanged.
  - q=1: single error at position s (s=0 means p0). Flip cw[s] and report status 01.
  - q=0, s≠0: double error, status 10. Data is extracted uncorrected.
- **Decode output.** dst hi = {status[1:0], 3'b000, d[11:9]}, dst lo = d[8:1].
- **FSM states.** IDLE → RD_LO → RD_HI → CAP → WR_LO → WR_HI → (i<N_MSG-1 ? RD_LO with i+1 : DONE).
  - RD_LO drives src lo address.
  - RD_HI drives src hi address and captures the lo byte.
  - CAP captures the hi byte and registers the codec result.
  - WR_LO and WR_HI assert `mem_we` with the dst addresses.
- **Start acceptance.** DONE + `start` → RD_LO; this also clears `done` and both counters and latches `mode`. `start` while busy is ignored.
- **In-place operation.** `SRC_BASE` == `DST_BASE` is legal, because each message's reads complete before its writes. Partially overlapping regions are unsupported.

## Timing
- **Reset values.** IDLE, `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counters=0, index=0.
- **Start.** `start` is sampled high at edge 0; `busy` rises and RD_LO is active from edge 0.
- **Per-message cost.** Exactly 5 cycles. Last WR_HI at cycle 5·N_MSG−1; `busy` falls and `done` rises at edge 5·N_MSG. For N_MSG=15, `done` is high 75 cycles after start.
- **Counter updates.** Counters update in CAP; they are stable whenever `done`=1.
- **Idle outputs.** `mem_we` is high only in WR_LO/WR_HI. `mem_addr` and `mem_wdata` are don't-care when `mem_we`=0 outside the RD states.
- **Reset mid-run.** Return to the reset values next edge. Memory already written stays as-is; no completion is signalled.
- **Simultaneous `start` and `reset`.** `reset` wins.

## Structure
- **Package `secded_pkg`.**
  - typedefs `data_t` (logic [11:1]) and `cw_t` (logic [15:0]).
  - enum `status_e` {ST_OK=2'b00, ST_SGL=2'b01, ST_DBL=2'b10}.
  - FSM state enum.
  - functions `encode(data_t)` and `syndrome(cw_t)`.
- **Sub-module `secded_codec`.** Combinational; inputs mode and cw or data, outputs result word and status. The engine FSM, address generation and counters stay in `secded_engine`.

## Test plan
- **Encode patterns.** Encode, N_MSG=3, sources 11'h000, 11'h7FF, 11'h001 → dst words 16'h0000, 16'hFFFF, 16'h000F; `done` at cycle 15.
- **Clean and single-error decode.** Decode of 16'h000F → hi 8'h00, lo 8'h01. Decode of 16'h002F (bit 5 flipped) → hi 8'h40, lo 8'h01, `cnt_single`=1.
- **Parity-bit error.** Decode of 16'hFFFE (p0 flipped) → hi 8'h47, lo 8'hFF, status single.
- **Double error.** Decode of 16'hFFF9 (bits 1,2 flipped) → hi 8'h87, lo 8'hFF, `cnt_double`=1, `cnt_single`=0.
- **Regression and round-trip.** 15 random messages encode and compare against the reference parity equations. Then run decode in place (SRC=DST=30) after random single-bit flips: all data restored with status 01.
- **Handshake.** `reset` asserted mid-run at cycle 7 → `busy`=0 and `done`=0 next cycle, `mem_we`=0. `start` during `busy` is ignored and total latency is unchanged.
